// File: rtl/cr_time_reg_bank.sv
// Staged/committed bank of time-field registers feeding the display path.
// Optional build macro BCD_CHECK_EN adds BCD-digit and per-channel limit checks on writes.
module cr_time_reg_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int AW       = 2,
  parameter logic [CHANNELS*WIDTH-1:0] LIMITS = {8'h23, 8'h59, 8'h59}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      commit,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] dato_out,
  output logic [CHANNELS-1:0]       stage_mask,
  output logic                      commit_ack,
  output logic                      wr_err
);

  logic [CHANNELS*WIDTH-1:0] r_stage;
  logic [CHANNELS*WIDTH-1:0] r_dato;
  logic [CHANNELS-1:0]       r_mask;
  logic                      r_commit_ack;
  logic                      r_wr_err;

  logic w_addr_ok;
  logic w_val_ok;
  logic w_wr_ok;
  logic w_wr_rej;

  // Widen by one bit so CHANNELS == 2**AW still compares correctly.
  assign w_addr_ok = ({1'b0, wr_addr} < (AW+1)'(CHANNELS));

`ifdef BCD_CHECK_EN
  logic [WIDTH-1:0] w_lim;

  function automatic logic f_bcd_ok(input logic [WIDTH-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int n = 0; n < WIDTH/4; n++)
      if (d[n*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  always_comb begin
    w_lim = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (wr_addr == AW'(i)) w_lim = LIMITS[i*WIDTH +: WIDTH];
  end

  assign w_val_ok = f_bcd_ok(wr_data) && (wr_data <= w_lim);
`else
  assign w_val_ok = 1'b1;
`endif

  assign w_wr_ok  = wr_en & w_addr_ok & w_val_ok;
  assign w_wr_rej = wr_en & ~(w_addr_ok & w_val_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage      <= '0;
      r_dato       <= '0;
      r_mask       <= '0;
      r_commit_ack <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_commit_ack <= 1'b0;
      r_wr_err     <= 1'b0;
      if (clear) begin
        r_stage <= '0;
        r_mask  <= '0;
      end else begin
        r_wr_err <= w_wr_rej;
        for (int i = 0; i < CHANNELS; i++) begin
          if (w_wr_ok && (wr_addr == AW'(i))) begin
            r_stage[i*WIDTH +: WIDTH] <= wr_data;
            if (!commit) r_mask[i] <= 1'b1;
          end
        end
        if (commit) begin
          // A same-cycle accepted write bypasses staging straight into the commit.
          for (int i = 0; i < CHANNELS; i++) begin
            if (w_wr_ok && (wr_addr == AW'(i)))
              r_dato[i*WIDTH +: WIDTH] <= wr_data;
            else if (r_mask[i])
              r_dato[i*WIDTH +: WIDTH] <= r_stage[i*WIDTH +: WIDTH];
          end
          r_mask       <= '0;
          r_commit_ack <= 1'b1;
        end
      end
    end
  end

  assign dato_out   = r_dato;
  assign stage_mask = r_mask;
  assign commit_ack = r_commit_ack;
  assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_cr_time_reg_bank.sv
// Scoreboard bench for cr_time_reg_bank: expected ack/err snapshots are queued by the
// stimulus and consumed by a monitor whenever the DUT pulses commit_ack or wr_err.
module tb_cr_time_reg_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        commit = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] dato_out;
  logic [2:0]  stage_mask;
  logic        commit_ack;
  logic        wr_err;

  typedef struct {
    logic [23:0] dato;
    logic [2:0]  mask;
  } exp_t;

  exp_t ack_q[$];
  exp_t err_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  cr_time_reg_bank dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .clear      (clear),
    .dato_out   (dato_out),
    .stage_mask (stage_mask),
    .commit_ack (commit_ack),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock of stimulus; inputs return to idle right after the edge.
  task automatic step(input logic en, input logic [1:0] addr, input logic [7:0] data,
                      input logic cm, input logic cl);
    wr_en = en; wr_addr = addr; wr_data = data; commit = cm; clear = cl;
    @(posedge clk); #1;
    wr_en = 1'b0; commit = 1'b0; clear = 1'b0;
  endtask

  task automatic exp_ack(input logic [23:0] d);
    exp_t e;
    e.dato = d; e.mask = 3'b000;
    ack_q.push_back(e);
  endtask

  task automatic exp_err(input logic [23:0] d, input logic [2:0] m);
    exp_t e;
    e.dato = d; e.mask = m;
    err_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (commit_ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else begin
          e = ack_q.pop_front();
          chk("ack_dato", 32'(dato_out), 32'(e.dato));
          chk("ack_mask", 32'(stage_mask), 32'(e.mask));
        end
      end
      if (wr_err) begin
        if (err_q.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
        else begin
          e = err_q.pop_front();
          chk("err_dato", 32'(dato_out), 32'(e.dato));
          chk("err_mask", 32'(stage_mask), 32'(e.mask));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_dato", 32'(dato_out), 32'h0);
    chk("rst_mask", 32'(stage_mask), 32'h0);
    chk("rst_ack", 32'(commit_ack), 32'h0);
    chk("rst_err", 32'(wr_err), 32'h0);

    // 1: stage sec/hour then commit
    step(1'b1, 2'd0, 8'h45, 1'b0, 1'b0);
    chk("t1_mask_a", 32'(stage_mask), 32'b001);
    step(1'b1, 2'd2, 8'h12, 1'b0, 1'b0);
    chk("t1_mask_b", 32'(stage_mask), 32'b101);
    exp_ack(24'h120045);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("t1_ack_one_cycle", 32'(commit_ack), 32'h0);

    // 2: partial update keeps other channels
    step(1'b1, 2'd1, 8'h30, 1'b0, 1'b0);
    exp_ack(24'h123045);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);

    // 3: write bypasses into same-cycle commit
    exp_ack(24'h120745);
    step(1'b1, 2'd1, 8'h07, 1'b1, 1'b0);
    chk("t3_dato", 32'(dato_out), 32'h120745);

    // 4: bad address
    exp_err(24'h120745, 3'b000);
    step(1'b1, 2'd3, 8'h55, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("t4_err_one_cycle", 32'(wr_err), 32'h0);

    // 5: clear beats commit; empty commit still acks
    step(1'b1, 2'd0, 8'h11, 1'b0, 1'b0);
    chk("t5_mask_staged", 32'(stage_mask), 32'b001);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
    chk("t5_no_ack", 32'(commit_ack), 32'h0);
    chk("t5_mask", 32'(stage_mask), 32'h0);
    chk("t5_dato", 32'(dato_out), 32'h120745);
    exp_ack(24'h120745);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);

    // clear drops writes, even rejected ones, without wr_err
    step(1'b1, 2'd2, 8'h09, 1'b0, 1'b1);
    chk("clr_wr_mask", 32'(stage_mask), 32'h0);
    step(1'b1, 2'd3, 8'h09, 1'b0, 1'b1);
    chk("clr_bad_err", 32'(wr_err), 32'h0);

    // back-to-back commits: two acks
    step(1'b1, 2'd0, 8'h01, 1'b0, 1'b0);
    exp_ack(24'h120701);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    exp_ack(24'h120701);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);

    // reset mid-sequence wins over commit
    step(1'b1, 2'd2, 8'h05, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 2'd3, 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    chk("rst2_dato", 32'(dato_out), 32'h0);
    chk("rst2_mask", 32'(stage_mask), 32'h0);
    chk("rst2_ack", 32'(commit_ack), 32'h0);
    chk("rst2_err", 32'(wr_err), 32'h0);

    // 6: value checking (or its absence)
`ifdef BCD_CHECK_EN
    exp_err(24'h000000, 3'b000);
    step(1'b1, 2'd2, 8'h24, 1'b0, 1'b0);
    exp_err(24'h000000, 3'b000);
    step(1'b1, 2'd0, 8'h5A, 1'b0, 1'b0);
    chk("t6_mask_rej", 32'(stage_mask), 32'b000);
    step(1'b1, 2'd2, 8'h23, 1'b0, 1'b0);
    chk("t6_mask_ok", 32'(stage_mask), 32'b100);
    exp_ack(24'h230000);
`else
    step(1'b1, 2'd2, 8'h24, 1'b0, 1'b0);
    step(1'b1, 2'd0, 8'h5A, 1'b0, 1'b0);
    chk("t6_mask_acc", 32'(stage_mask), 32'b101);
    step(1'b1, 2'd2, 8'h23, 1'b0, 1'b0);
    chk("t6_mask_ok", 32'(stage_mask), 32'b101);
    exp_ack(24'h23005A);
`endif
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);

    repeat (3) step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    chk("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
